spi_arbiter: RTL and testbench
==============================

Name: spi_arbiter

Overview:
- Sequences the byte-level SPI engine (`start` / `data_tx` / `data_rx` / `busy`) into multi-byte chip-selected transactions.
- Shares the engine between two requesters (CPU peripheral port, boot/flash loader) with round-robin arbitration.
- Owns per-device chip select, CS setup/hold timing and an engine-busy timeout.
- Sits between the memory-mapped peripheral bus and the `spi` engine instance.

Parameters:
- CS_SETUP, 2, cycles between cs_n falling and first spi_start
- CS_HOLD, 2, cycles between last byte captured and cs_n rising
- TIMEOUT, 64, max cycles spent waiting on any single spi_busy edge

Ports:
- raw_clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  2  per-requester transaction request; held high for the whole transaction
- grant  output  2  one-hot owner of the engine
- tx_valid  input  2  per-requester byte available
- tx_data  input  16  byte for requester i on [8i+7:8i]
- tx_last  input  2  current byte is the final byte of the transaction
- tx_ready  output  2  one-cycle pulse: byte accepted
- rx_valid  output  1  one-cycle pulse: rx_data valid for current owner
- rx_data  output  8  received byte
- error  output  1  sticky timeout flag; cleared at next grant
- cs_n  output  2  active-low chip select; device i tied to requester i
- spi_start  output  1  to engine `start`
- spi_data_tx  output  8  to engine `data_tx`
- spi_data_rx  input  8  from engine `data_rx`
- spi_busy  input  1  from engine `busy`

Behaviour:
- Reset values:
  - grant=0, tx_ready=0, rx_valid=0, rx_data=0, error=0, cs_n=2'b11, spi_start=0, spi_data_tx=0.
  - Round-robin pointer set so requester 0 wins the first tie.
- The engine has no reset. After reset the controller does not leave IDLE until spi_busy=0 has been sampled.
- States: IDLE, SETUP, LOAD, START, WAIT_HI, WAIT_LO, CAPTURE, HOLD.
- IDLE:
  - On any req, grant the requester not served last; a lone requester always wins.
  - Set grant and drop its cs_n in the same edge.
  - Clear error; go to SETUP.
- SETUP: count CS_SETUP cycles, then go to LOAD.
- LOAD:
  - Wait for tx_valid[owner].
  - On tx_valid, latch tx_data into spi_data_tx and latch tx_last.
  - Pulse tx_ready[owner] for exactly one cycle; go to START.
  - While waiting, cs_n stays low indefinitely (no timeout).
- START:
  - spi_start=1 for exactly one cycle; go to WAIT_HI.
  - spi_data_tx is stable from LOAD through WAIT_LO.
- WAIT_HI: wait for spi_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for spi_busy=0, then go to CAPTURE.
- CAPTURE:
  - rx_data<=spi_data_rx and rx_valid pulses one cycle.
  - If the latched tx_last=1 or req[owner]=0, go to HOLD; otherwise go to LOAD.
- HOLD:
  - Count CS_HOLD cycles.
  - Then cs_n[owner]<=1 and grant<=0; update the round-robin pointer; return to IDLE.
  - A new grant cannot occur in the same cycle as the release, so cs_n is high for at least 1 cycle between transactions.
- Timeout:
  - Separate counter for WAIT_HI and WAIT_LO, reset on entry to each.
  - Reaching TIMEOUT sets error=1, skips CAPTURE (no rx_valid) and goes to HOLD.
- req dropped mid-transaction:
  - Dropped in LOAD: go directly to HOLD, no further byte issued.
  - Dropped in START/WAIT_*: the in-flight byte completes and is delivered, then HOLD.
- Requests arriving while the engine is owned are ignored until IDLE; no pre-emption.
- Throughput: per byte, the LOAD→CAPTURE overhead beyond engine time is 3 cycles.
- Only one cs_n bit is ever low. grant is always one-hot or zero.

Decomposition:
- Shared package holds:
  - state encodings (3-bit, values 0-7 in listed order);
  - requester count 2;
  - reset constant 2'b11 for cs_n.
- One natural sub-module: `rr_arbiter2`, the 2-way round-robin grant with last-served pointer, combinational grant plus registered pointer update.

Test Plan:
- Single 3-byte transaction on requester 0 (tx 0xA5, 0x3C, 0x81; miso loopback):
  - cs_n[0] falls;
  - first spi_start after CS_SETUP=2 cycles;
  - rx_valid pulses three times with 0xA5, 0x3C, 0x81;
  - cs_n[0] rises CS_HOLD=2 cycles after the last rx_valid;
  - error=0.
- req 2'b11 asserted together, each requester sending 1 byte:
  - grant=01 first, then 10, then 01 again on repeat;
  - cs_n never 2'b00.
- Requester 1 holds tx_valid low for 20 cycles between byte 1 and byte 2: cs_n[1] stays 0 throughout and no extra spi_start is issued.
- Requester 0 drops req while the engine is busy on byte 2 of 4:
  - byte 2 rx_valid is still delivered;
  - no byte-3 tx_ready;
  - cs_n[0] rises 2 cycles later.
- Engine model holds spi_busy=1 forever:
  - error=1 after 64 cycles in WAIT_LO;
  - no rx_valid;
  - cs_n released;
  - error cleared at the next grant.
- Reset asserted in WAIT_LO:
  - next cycle cs_n=11, grant=0, spi_start=0;
  - no new grant until spi_busy has been sampled low.

Source files
------------

// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam logic [NUM_REQ-1:0] CS_IDLE = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        LOAD    = 3'd2,
        START   = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5,
        CAPTURE = 3'd6,
        HOLD    = 3'd7
    } state_t;

endpackage

// File: rtl/spi_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: combinational decision, registered last-served pointer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);

    // Holds the index of the requester served most recently; starts at 1 so 0 wins the first tie.
    logic last_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            last_reg <= 1'b1;
        end else if (update) begin
            last_reg <= served;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_arbiter.sv
// Multi-byte chip-selected SPI transactions over a shared byte engine, two requesters, round-robin.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic [1:0]  req,
    output logic [1:0]  grant,
    input  logic [1:0]  tx_valid,
    input  logic [15:0] tx_data,
    input  logic [1:0]  tx_last,
    output logic [1:0]  tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        error,
    output logic [1:0]  cs_n,
    output logic        spi_start,
    output logic [7:0]  spi_data_tx,
    input  logic [7:0]  spi_data_rx,
    input  logic        spi_busy
);

    localparam int CNT_W = 8;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    state_t           state_reg;
    logic [1:0]       grant_reg;
    logic             owner_reg;
    logic [1:0]       cs_n_reg;
    logic [1:0]       tx_ready_reg;
    logic             rx_valid_reg;
    logic [7:0]       rx_data_reg;
    logic             error_reg;
    logic             spi_start_reg;
    logic [7:0]       spi_data_tx_reg;
    logic             last_reg;
    logic             engine_idle_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [TMO_W-1:0] tmo_reg;

    logic [1:0] arb_grant;
    logic       hold_done;
    logic       tmo_hit;
    logic [7:0] tx_byte [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_byte
            assign tx_byte[gi] = tx_data[8*gi +: 8];
        end
    endgenerate

    assign hold_done = (state_reg == HOLD) && (cnt_reg == CNT_W'(CS_HOLD - 1));
    assign tmo_hit   = (tmo_reg == TMO_W'(TIMEOUT - 1));

    rr_arbiter2 u_rr (
        .clk    (raw_clk),
        .srst   (reset),
        .req    (req),
        .update (hold_done),
        .served (owner_reg),
        .grant  (arb_grant)
    );

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            grant_reg       <= 2'b00;
            owner_reg       <= 1'b0;
            cs_n_reg        <= CS_IDLE;
            tx_ready_reg    <= 2'b00;
            rx_valid_reg    <= 1'b0;
            rx_data_reg     <= 8'h00;
            error_reg       <= 1'b0;
            spi_start_reg   <= 1'b0;
            spi_data_tx_reg <= 8'h00;
            last_reg        <= 1'b0;
            engine_idle_reg <= 1'b0;
            cnt_reg         <= '0;
            tmo_reg         <= '0;
        end else begin
            tx_ready_reg  <= 2'b00;
            rx_valid_reg  <= 1'b0;
            spi_start_reg <= 1'b0;
            // The engine is not reset with us; it may still be mid-byte.
            if (!spi_busy) engine_idle_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (engine_idle_reg && (req != 2'b00)) begin
                        grant_reg <= arb_grant;
                        owner_reg <= arb_grant[1];
                        cs_n_reg  <= ~arb_grant;
                        error_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == CNT_W'(CS_SETUP - 1)) state_reg <= LOAD;
                    else cnt_reg <= cnt_reg + 1'b1;
                end
                LOAD: begin
                    if (!req[owner_reg]) begin
                        cnt_reg   <= '0;
                        state_reg <= HOLD;
                    end else if (tx_valid[owner_reg]) begin
                        spi_data_tx_reg <= tx_byte[owner_reg];
                        last_reg        <= tx_last[owner_reg];
                        tx_ready_reg    <= grant_reg;
                        spi_start_reg   <= 1'b1;
                        state_reg       <= START;
                    end
                end
                START: begin
                    tmo_reg   <= '0;
                    state_reg <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (spi_busy) begin
                        tmo_reg   <= '0;
                        state_reg <= WAIT_LO;
                    end else if (tmo_hit) begin
                        error_reg <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= HOLD;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!spi_busy) begin
                        state_reg <= CAPTURE;
                    end else if (tmo_hit) begin
                        error_reg <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= HOLD;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                CAPTURE: begin
                    rx_data_reg  <= spi_data_rx;
                    rx_valid_reg <= 1'b1;
                    if (last_reg || !req[owner_reg]) begin
                        cnt_reg   <= '0;
                        state_reg <= HOLD;
                    end else begin
                        state_reg <= LOAD;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        cs_n_reg  <= CS_IDLE;
                        grant_reg <= 2'b00;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant       = grant_reg;
    assign cs_n        = cs_n_reg;
    assign tx_ready    = tx_ready_reg;
    assign rx_valid    = rx_valid_reg;
    assign rx_data     = rx_data_reg;
    assign error       = error_reg;
    assign spi_start   = spi_start_reg;
    assign spi_data_tx = spi_data_tx_reg;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a loopback byte-engine model.
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  grant;
    logic [1:0]  tx_valid = 2'b00;
    logic [15:0] tx_data = 16'h0000;
    logic [1:0]  tx_last = 2'b00;
    logic [1:0]  tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        error;
    logic [1:0]  cs_n;
    logic        spi_start;
    logic [7:0]  spi_data_tx;
    logic [7:0]  spi_data_rx = 8'h00;
    logic        spi_busy = 1'b0;

    spi_arbiter dut (
        .raw_clk     (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .error       (error),
        .cs_n        (cs_n),
        .spi_start   (spi_start),
        .spi_data_tx (spi_data_tx),
        .spi_data_rx (spi_data_rx),
        .spi_busy    (spi_busy)
    );

    always #5 clk = ~clk;

    // Byte engine: busy for 4 cycles after start, echoes the transmitted byte.
    logic       force_busy = 1'b0;
    logic [3:0] eng_cnt = 4'd0;
    always @(posedge clk) begin
        if (force_busy) begin
            spi_busy <= 1'b1;
        end else if (spi_start) begin
            spi_busy    <= 1'b1;
            eng_cnt     <= 4'd4;
            spi_data_rx <= spi_data_tx;
        end else if (eng_cnt != 4'd0) begin
            eng_cnt <= eng_cnt - 4'd1;
            if (eng_cnt == 4'd1) spi_busy <= 1'b0;
        end else begin
            spi_busy <= 1'b0;
        end
    end

    bit bad_cs = 1'b0;
    bit bad_grant = 1'b0;
    always @(negedge clk) begin
        if (cs_n == 2'b00) bad_cs = 1'b1;
        if (!$onehot0(grant)) bad_grant = 1'b1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pattern [4];
    logic [7:0] rx_q [$];
    int  t_fall, t_start, t_rx, t_rise, t_err, n_start, n_ready;
    bit  cs_broken, err_at_fall, err_seen;

    // Drives one transaction for requester r and records what the DUT did, one sample per cycle.
    task automatic run_txn(input int r, input int nbytes, input int gap_idx, input int gap_len,
                           input int drop_idx, input int budget);
        int idx = 0;
        int gap_cnt = 0;
        bit fell = 1'b0;
        rx_q.delete();
        t_fall = -1; t_start = -1; t_rx = -1; t_rise = -1; t_err = -1;
        n_start = 0; n_ready = 0; cs_broken = 0; err_at_fall = 0; err_seen = 0;
        tx_data[8*r +: 8] = pattern[0];
        tx_last[r] = (nbytes == 1);
        tx_valid[r] = 1'b1;
        req[r] = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!fell && cs_n[r] == 1'b0) begin
                fell = 1'b1; t_fall = c; err_at_fall = error;
            end
            if (fell && cs_n[r] == 1'b1) begin
                t_rise = c;
                break;
            end
            if (spi_start) begin
                n_start++;
                if (n_start == 1) t_start = c;
            end
            if (rx_valid) begin
                rx_q.push_back(rx_data); t_rx = c;
            end
            if (error && !err_seen) begin
                err_seen = 1'b1; t_err = c;
            end
            if (gap_cnt > 0) begin
                gap_cnt--;
                if (gap_cnt == 0) tx_valid[r] = 1'b1;
            end
            if (tx_ready[r]) begin
                n_ready++; idx++;
                if (idx < nbytes) begin
                    tx_data[8*r +: 8] = pattern[idx];
                    tx_last[r] = (idx == nbytes - 1);
                    if (idx == gap_idx) begin
                        tx_valid[r] = 1'b0; gap_cnt = gap_len;
                    end
                end else begin
                    tx_valid[r] = 1'b0;
                end
            end
            if (drop_idx > 0 && idx == drop_idx && spi_busy) req[r] = 1'b0;
        end
        req[r] = 1'b0;
        tx_valid[r] = 1'b0;
        tx_last[r] = 1'b0;
    endtask

    initial begin
        logic [1:0] gseq [3];
        logic [1:0] prev;
        int ng;
        bit early, seen;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_pulses", {tx_ready, rx_valid, spi_start, error}, 5'b0);
        check("rst_data", {rx_data, spi_data_tx}, 16'h0000);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Simultaneous requests, one byte each: round-robin from requester 0
        tx_data = 16'h2211; tx_last = 2'b11; tx_valid = 2'b11; req = 2'b11;
        ng = 0; prev = 2'b00;
        for (int c = 0; c < 300 && ng < 3; c++) begin
            @(negedge clk);
            if (grant != 2'b00 && prev == 2'b00) begin
                gseq[ng] = grant; ng++;
            end
            prev = grant;
        end
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cs_n == 2'b11) begin seen = 1'b1; break; end
        end
        req = 2'b00; tx_valid = 2'b00; tx_last = 2'b00;
        check("rr_count", ng, 3);
        check("rr_first", gseq[0], 2'b01);
        check("rr_second", gseq[1], 2'b10);
        check("rr_third", gseq[2], 2'b01);
        check("rr_release", seen, 1'b1);
        repeat (3) @(negedge clk);

        // Three-byte transaction on requester 0
        pattern[0] = 8'hA5; pattern[1] = 8'h3C; pattern[2] = 8'h81; pattern[3] = 8'h00;
        run_txn(0, 3, -1, 0, -1, 200);
        check("t1_setup_lat", t_start - t_fall, 3);  // 2 SETUP cycles + LOAD
        check("t1_rx_count", rx_q.size(), 3);
        check("t1_rx_bytes", {rx_q[0], rx_q[1], rx_q[2]}, 24'hA53C81);
        check("t1_starts", n_start, 3);
        check("t1_hold_lat", t_rise - t_rx, 2);
        check("t1_error", error, 1'b0);
        repeat (3) @(negedge clk);

        // Requester 1 stalls 20 cycles between byte 1 and byte 2
        pattern[0] = 8'h11; pattern[1] = 8'h22; pattern[2] = 8'h33;
        run_txn(1, 3, 1, 20, -1, 300);
        check("gap_cs_rose", t_rise > 0, 1'b1);
        check("gap_starts", n_start, 3);
        check("gap_rx_bytes", {rx_q.size() == 3, rx_q[0], rx_q[1], rx_q[2]}, {1'b1, 24'h112233});
        check("gap_duration", t_rise - t_fall >= 40, 1'b1);
        repeat (3) @(negedge clk);

        // Requester 0 drops req while byte 2 of 4 is in flight
        pattern[0] = 8'h01; pattern[1] = 8'h02; pattern[2] = 8'h03; pattern[3] = 8'h04;
        run_txn(0, 4, -1, 0, 2, 200);
        check("drop_rx_count", rx_q.size(), 2);
        check("drop_rx_byte2", rx_q[1], 8'h02);
        check("drop_ready", n_ready, 2);
        check("drop_hold_lat", t_rise - t_rx, 2);
        repeat (3) @(negedge clk);

        // Engine stuck busy: timeout after 64 cycles in WAIT_LO
        force_busy = 1'b1;
        pattern[0] = 8'h77;
        run_txn(0, 1, -1, 0, -1, 300);
        check("tmo_rx_count", rx_q.size(), 0);
        check("tmo_err_lat", t_err - t_start, 66);  // START + WAIT_HI + 64 WAIT_LO
        check("tmo_hold_lat", t_rise - t_err, 2);
        check("tmo_sticky", error, 1'b1);
        force_busy = 1'b0;
        repeat (3) @(negedge clk);
        pattern[0] = 8'h9E;
        run_txn(1, 1, -1, 0, -1, 200);
        check("tmo_err_cleared", err_at_fall, 1'b0);
        check("tmo_next_rx", {rx_q.size() == 1, rx_q[0]}, {1'b1, 8'h9E});
        repeat (3) @(negedge clk);

        // Reset while in WAIT_LO, engine still busy afterwards
        force_busy = 1'b1;
        tx_data[7:0] = 8'h5A; tx_last[0] = 1'b1; tx_valid[0] = 1'b1; req[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (spi_start) begin seen = 1'b1; break; end
        end
        check("rst2_started", seen, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_cs_n", cs_n, 2'b11);
        check("rst2_grant", grant, 2'b00);
        check("rst2_start", spi_start, 1'b0);
        reset = 1'b0;
        early = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (grant != 2'b00) early = 1'b1;
        end
        check("rst2_no_grant_busy", early, 1'b0);
        force_busy = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant != 2'b00) begin seen = 1'b1; break; end
        end
        check("rst2_grant_after", {seen, grant}, {1'b1, 2'b01});
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cs_n == 2'b11) begin seen = 1'b1; break; end
        end
        req = 2'b00; tx_valid = 2'b00; tx_last = 2'b00;
        check("rst2_release", seen, 1'b1);

        check("never_both_cs", bad_cs, 1'b0);
        check("grant_onehot", bad_grant, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
